// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the memory requester
package mem_pkg;

    localparam int WORD_W      = 16;
    localparam int MEM_LAT_DEF = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        WAIT   = 3'd2,
        DONE   = 3'd3,
        HALTED = 3'd4
    } state_e;

endpackage

// File: rtl/mem_lat_cnt.sv
// rtl/mem_lat_cnt.sv - loadable down-counter with zero flag for read latency
module mem_lat_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_req_ctrl.sv
// rtl/mem_req_ctrl.sv - MEM-stage requester for the multi-cycle data memory
module mem_req_ctrl
    import mem_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEF,
    parameter int CNT_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_en,
    input  logic              pipe_wr,
    input  logic [WORD_W-1:0] pipe_addr,
    input  logic [WORD_W-1:0] pipe_wdata,
    input  logic              halt,
    output logic [WORD_W-1:0] pipe_rdata,
    output logic              pipe_stall,
    output logic              pipe_done,
    output logic              pipe_err,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic              mem_stall,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              mem_dump
);

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] addr_q, wdata_q, rdata_q;
    logic              wr_q;
    logic              latch_req;
    logic              capture;
    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_zero;

    mem_lat_cnt #(
        .CNT_W (CNT_W)
    ) u_lat_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (LAT_LOAD),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d    = state_q;
        latch_req  = 1'b0;
        capture    = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        pipe_stall = 1'b0;
        pipe_done  = 1'b0;
        pipe_err   = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_dump   = 1'b0;
        case (state_q)
            IDLE: begin
                // Gated by rst so every combinational output is 0 while reset is held.
                if (rst) begin
                    if (pipe_en) begin
                        if (pipe_addr[0]) begin
                            pipe_err = 1'b1;
                        end else begin
                            latch_req  = 1'b1;
                            pipe_stall = 1'b1;
                            state_d    = ISSUE;
                        end
                    end else if (halt) begin
                        mem_dump = 1'b1;
                        state_d  = HALTED;
                    end
                end
            end
            ISSUE: begin
                pipe_stall = 1'b1;
                mem_rd     = !wr_q;
                mem_wr     = wr_q;
                if (!mem_stall) begin
                    if (wr_q) begin
                        state_d = DONE;
                    end else begin
                        cnt_load = 1'b1;
                        state_d  = WAIT;
                    end
                end
            end
            WAIT: begin
                pipe_stall = 1'b1;
                if (cnt_zero) begin
                    capture = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            DONE: begin
                pipe_done = 1'b1;
                state_d   = IDLE;
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (latch_req) begin
                addr_q  <= pipe_addr;
                wdata_q <= pipe_wdata;
                wr_q    <= pipe_wr;
            end
            if (capture) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    assign pipe_rdata = rdata_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb/tb_mem_req_ctrl.sv - directed vector bench for mem_req_ctrl
module tb_mem_req_ctrl;

    localparam int LAT = 2;

    logic        clk;
    logic        rst;
    logic        pipe_en;
    logic        pipe_wr;
    logic [15:0] pipe_addr;
    logic [15:0] pipe_wdata;
    logic        halt;
    logic [15:0] pipe_rdata;
    logic        pipe_stall;
    logic        pipe_done;
    logic        pipe_err;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic        mem_stall;
    logic [15:0] mem_rdata;
    logic        mem_dump;

    int checks = 0;
    int errors = 0;

    mem_req_ctrl #(
        .MEM_LAT (LAT),
        .CNT_W   (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_en    (pipe_en),
        .pipe_wr    (pipe_wr),
        .pipe_addr  (pipe_addr),
        .pipe_wdata (pipe_wdata),
        .halt       (halt),
        .pipe_rdata (pipe_rdata),
        .pipe_stall (pipe_stall),
        .pipe_done  (pipe_done),
        .pipe_err   (pipe_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_stall  (mem_stall),
        .mem_rdata  (mem_rdata),
        .mem_dump   (mem_dump)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // flags = {stall, done, err, rd, wr, dump}
    typedef struct {
        string       name;
        logic        rst;
        logic        en;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        halt;
        logic        mstall;
        logic [15:0] mrdata;
        logic [5:0]  flags;
        logic [15:0] e_rdata;
        logic [15:0] e_maddr;
        logic [15:0] e_mwdata;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(string n, logic r, logic en, logic wr, logic [15:0] a,
                                logic [15:0] wd, logic h, logic ms, logic [15:0] mrd,
                                logic [5:0] f, logic [15:0] erd, logic [15:0] ema,
                                logic [15:0] emw);
        vec_t v;
        v.name = n; v.rst = r; v.en = en; v.wr = wr; v.addr = a; v.wdata = wd;
        v.halt = h; v.mstall = ms; v.mrdata = mrd; v.flags = f;
        v.e_rdata = erd; v.e_maddr = ema; v.e_mwdata = emw;
        vecs.push_back(v);
    endfunction

    function automatic logic [53:0] outs();
        return {pipe_stall, pipe_done, pipe_err, mem_rd, mem_wr, mem_dump,
                pipe_rdata, mem_addr, mem_wdata};
    endfunction

    task automatic check_bit(string n, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", n, act, exp);
        end
    endtask

    task automatic check_word(string n, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    initial begin
        int lat;
        logic [53:0] exp_o;

        rst = 1'b0; pipe_en = 1'b0; pipe_wr = 1'b0; pipe_addr = '0; pipe_wdata = '0;
        halt = 1'b0; mem_stall = 1'b0; mem_rdata = 16'hDEAD;

        add("rst_hold", 0, 1, 0, 16'h0040, 16'h0000, 0, 0, 16'hDEAD, 6'b000000, 16'h0000, 16'h0000, 16'h0000);
        add("st_c0",    1, 1, 1, 16'h0040, 16'h1234, 0, 0, 16'hDEAD, 6'b100000, 16'h0000, 16'h0000, 16'h0000);
        add("st_c1",    1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'hDEAD, 6'b100010, 16'h0000, 16'h0040, 16'h1234);
        add("st_c2",    1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'hDEAD, 6'b010000, 16'h0000, 16'h0040, 16'h1234);
        add("ld_c0",    1, 1, 0, 16'h0040, 16'h0000, 0, 0, 16'hDEAD, 6'b100000, 16'h0000, 16'h0040, 16'h1234);
        add("ld_c1",    1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'hDEAD, 6'b100100, 16'h0000, 16'h0040, 16'h0000);
        add("ld_c2",    1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'hDEAD, 6'b100000, 16'h0000, 16'h0040, 16'h0000);
        add("ld_c3",    1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'hBEEF, 6'b100000, 16'h0000, 16'h0040, 16'h0000);
        add("ld_c4",    1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'hDEAD, 6'b010000, 16'hBEEF, 16'h0040, 16'h0000);
        add("err_c0",   1, 1, 0, 16'h0041, 16'h0000, 0, 0, 16'hDEAD, 6'b001000, 16'hBEEF, 16'h0040, 16'h0000);
        add("err_c1",   1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'hDEAD, 6'b000000, 16'hBEEF, 16'h0040, 16'h0000);
        add("sl_c0",    1, 1, 0, 16'h0080, 16'h0000, 0, 0, 16'hDEAD, 6'b100000, 16'hBEEF, 16'h0040, 16'h0000);
        add("sl_c1",    1, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'hDEAD, 6'b100100, 16'hBEEF, 16'h0080, 16'h0000);
        add("sl_c2",    1, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'hDEAD, 6'b100100, 16'hBEEF, 16'h0080, 16'h0000);
        add("sl_c3",    1, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'hDEAD, 6'b100100, 16'hBEEF, 16'h0080, 16'h0000);
        add("sl_c4",    1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'hDEAD, 6'b100100, 16'hBEEF, 16'h0080, 16'h0000);
        add("sl_c5",    1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'hDEAD, 6'b100000, 16'hBEEF, 16'h0080, 16'h0000);
        add("sl_c6",    1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h5A5A, 6'b100000, 16'hBEEF, 16'h0080, 16'h0000);
        add("sl_c7",    1, 1, 1, 16'h00C0, 16'h0000, 0, 0, 16'hDEAD, 6'b010000, 16'h5A5A, 16'h0080, 16'h0000);
        add("sl_c8",    1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'hDEAD, 6'b000000, 16'h5A5A, 16'h0080, 16'h0000);
        add("rs_c0",    1, 1, 0, 16'h0100, 16'h0000, 0, 0, 16'hDEAD, 6'b100000, 16'h5A5A, 16'h0080, 16'h0000);
        add("rs_c1",    1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'hDEAD, 6'b100100, 16'h5A5A, 16'h0100, 16'h0000);
        add("rs_c2",    0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'hDEAD, 6'b000000, 16'h0000, 16'h0000, 16'h0000);
        add("rs_c3",    1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h1111, 6'b000000, 16'h0000, 16'h0000, 16'h0000);
        add("rs_c4",    1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h1111, 6'b000000, 16'h0000, 16'h0000, 16'h0000);
        add("fr_c0",    1, 1, 0, 16'h0102, 16'h0000, 0, 0, 16'hDEAD, 6'b100000, 16'h0000, 16'h0000, 16'h0000);
        add("fr_c1",    1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'hDEAD, 6'b100100, 16'h0000, 16'h0102, 16'h0000);
        add("fr_c2",    1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'hDEAD, 6'b100000, 16'h0000, 16'h0102, 16'h0000);
        add("fr_c3",    1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h2222, 6'b100000, 16'h0000, 16'h0102, 16'h0000);
        add("fr_c4",    1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'hDEAD, 6'b010000, 16'h2222, 16'h0102, 16'h0000);
        add("hl_c0",    1, 1, 1, 16'h0200, 16'hCAFE, 1, 0, 16'hDEAD, 6'b100000, 16'h2222, 16'h0102, 16'h0000);
        add("hl_c1",    1, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'hDEAD, 6'b100010, 16'h2222, 16'h0200, 16'hCAFE);
        add("hl_c2",    1, 1, 0, 16'h0204, 16'h0000, 1, 0, 16'hDEAD, 6'b010000, 16'h2222, 16'h0200, 16'hCAFE);
        add("hl_c3",    1, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'hDEAD, 6'b000001, 16'h2222, 16'h0200, 16'hCAFE);
        add("hl_c4",    1, 1, 0, 16'h0204, 16'h0000, 1, 0, 16'hDEAD, 6'b000000, 16'h2222, 16'h0200, 16'hCAFE);
        add("hl_c5",    1, 1, 0, 16'h0205, 16'h0000, 1, 0, 16'hDEAD, 6'b000000, 16'h2222, 16'h0200, 16'hCAFE);
        add("hl_c6",    1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'hDEAD, 6'b000000, 16'h2222, 16'h0200, 16'hCAFE);

        @(negedge clk);
        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; pipe_en = vecs[i].en; pipe_wr = vecs[i].wr;
            pipe_addr = vecs[i].addr; pipe_wdata = vecs[i].wdata; halt = vecs[i].halt;
            mem_stall = vecs[i].mstall; mem_rdata = vecs[i].mrdata;
            #4;
            exp_o = {vecs[i].flags, vecs[i].e_rdata, vecs[i].e_maddr, vecs[i].e_mwdata};
            checks++;
            if (outs() !== exp_o) begin
                errors++;
                $display("FAIL %s: got %h expected %h", vecs[i].name, outs(), exp_o);
            end
        end

        // Leave HALTED via reset, then measure load latency with a bounded wait.
        @(negedge clk);
        rst = 1'b0; pipe_en = 1'b0; halt = 1'b0; mem_stall = 1'b0;
        @(negedge clk);
        rst = 1'b1; pipe_en = 1'b1; pipe_wr = 1'b0; pipe_addr = 16'h0300; mem_rdata = 16'h7777;
        lat = -1;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) begin
                @(negedge clk);
                pipe_en = 1'b0;
            end
            #4;
            if (pipe_done) begin
                lat = c;
                break;
            end
        end
        checks++;
        if (lat != 2 + LAT) begin
            errors++;
            $display("FAIL bounded_load_latency: got %0d expected %0d", lat, 2 + LAT);
        end
        check_word("bounded_load_rdata", pipe_rdata, 16'h7777);

        // Asynchronous reset between clock edges while ISSUE is held by mem_stall.
        @(negedge clk);
        pipe_en = 1'b1; pipe_addr = 16'h0400; mem_stall = 1'b1;
        @(negedge clk);
        pipe_en = 1'b0;
        #4;
        check_bit("async_pre_rd", mem_rd, 1'b1);
        check_word("async_pre_addr", mem_addr, 16'h0400);
        #2;
        rst = 1'b0;
        #1;
        check_bit("async_rd", mem_rd, 1'b0);
        check_bit("async_stall", pipe_stall, 1'b0);
        check_word("async_addr", mem_addr, 16'h0000);
        @(negedge clk);
        rst = 1'b1; mem_stall = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #4;
            check_bit("async_no_done", pipe_done, 1'b0);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
